shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: DIV, default 2, system clocks per serial-clock half period; legal range 1..255.
REQ-002 Port: clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-003 Port: clear  in  1  reset, asynchronous and active-high.
REQ-004 Port: start  in  1  transfer request, sampled only in IDLE.
REQ-005 Port: pdata  in  32  word to serialize, captured on the accepted start.
REQ-006 Port: dir  in  1  order: 0 = MSB first (shift left), 1 = LSB first (shift right); captured on the accepted start.
REQ-007 Port: len  in  6  bit count, captured on the accepted start; 1..32 literal, 0 treated as 32, values 33..63 treated as 32.
REQ-008 Port: fill  in  1  serial fill bit driven into the vacated end during shifts.
REQ-009 Port: sh_Q  in  32  parallel output fed back from the 32-bit shift register.
REQ-010 Port: sh_S1, sh_S0  out  1 each  shift register mode: 00 hold, 01 shift right (SR into Q[31]), 10 shift left (SL into Q[0]), 11 parallel load.
REQ-011 Port: sh_SL, sh_SR  out  1 each  serial inputs to the shift register.
REQ-012 Port: sh_PData  out  32  parallel load data to the shift register.
REQ-013 Port: sout  out  1  serial data; sclk  out  1  serial clock; latch  out  1  strobe after the last bit.
REQ-014 Port: busy  out  1  transfer in progress; done  out  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, SHIFT, LATCH and DONE.
REQ-016 IDLE: mode 00; on start=1 it SHALL capture pdata, dir and len into registers and go to LOAD.
REQ-017 LOAD: exactly 1 cycle with mode 11 and sh_PData equal to the captured word; it SHALL then go to SHIFT with the bit and phase counters at 0.
REQ-018 SHIFT: each bit SHALL last 2*DIV cycles; the phase counter runs 0..2*DIV-1.
REQ-019 sclk SHALL be 0 for phases 0..DIV-1 and 1 for phases DIV..2*DIV-1.
REQ-020 sout SHALL equal sh_Q[31] when dir=0 and sh_Q[0] when dir=1 throughout SHIFT, so data is stable across the sclk rising edge.
REQ-021 Mode SHALL be 00 during SHIFT except in phase 2*DIV-1, where it is 10 (dir=0) or 01 (dir=1) for exactly one cycle.
REQ-022 sh_SL and sh_SR SHALL both equal fill during SHIFT.
REQ-023 At phase 2*DIV-1 of bit len-1, the FSM SHALL go to LATCH; otherwise the bit counter increments and the phase counter wraps to 0.
REQ-024 LATCH: latch=1 and mode 00 for DIV cycles, then the FSM goes to DONE.
REQ-025 DONE: done=1 for 1 cycle, busy=0, then the FSM returns to IDLE.
REQ-026 busy SHALL be 1 in LOAD, SHIFT and LATCH and 0 otherwise; start while busy=1 or in DONE SHALL be ignored.
REQ-027 Outside SHIFT, sout and sclk SHALL be 0; outside LOAD, sh_PData SHALL be 0.
REQ-028 Latency: taking the LOAD cycle as cycle 0, done SHALL assert in cycle 1 + len*2*DIV + DIV.
REQ-029 Changes to pdata, dir or len after acceptance SHALL NOT affect the transfer in progress.

Reset
REQ-030 clear=1 SHALL force IDLE immediately, clear all counters and captured registers, and drive all outputs to 0, including mode 00, at any point (including mid-transfer).
REQ-031 After clear deasserts, the first start sampled in IDLE SHALL begin a fresh transfer, with no residue from the aborted one.

Verification
REQ-032 DIV=2, pdata=0xA5000000, dir=0, len=8 -> sout per bit 1,0,1,0,0,1,0,1; 8 sclk pulses; latch high 2 cycles; done in cycle 35.
REQ-033 DIV=2, pdata=0x00000001, dir=1, len=0 -> 32 bits, first sout=1 then 31 zeros (fill=0); done in cycle 131.
REQ-034 start pulsed again during SHIFT with different pdata -> output stream unchanged; no second transfer begins.
REQ-035 clear=1 asserted at bit 5 of a 32-bit transfer -> busy, sclk, sout, latch and mode all 0 within the same cycle; a following start with len=4 gives exactly 4 sclk pulses.
REQ-036 DIV=1, len=1, fill=1, dir=0 -> one 2-cycle bit; sh_Q[0]=1 after the shift; done in cycle 4.
REQ-037 start held high continuously -> back-to-back transfers with exactly one IDLE cycle between each done and the next LOAD.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving an external 32-bit universal shift register: parallel load, serialize len bits
// with a divided serial clock, strobe latch, then pulse done. Outputs are decoded from state, so clear blanks them at once.
module shift_seq_ctrl #(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] pdata,
  input  logic        dir,
  input  logic [5:0]  len,
  input  logic        fill,
  input  logic [31:0] sh_Q,
  output logic        sh_S1,
  output logic        sh_S0,
  output logic        sh_SL,
  output logic        sh_SR,
  output logic [31:0] sh_PData,
  output logic        sout,
  output logic        sclk,
  output logic        latch,
  output logic        busy,
  output logic        done
);

  localparam int PW = $clog2(2 * DIV);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * DIV - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(DIV);
  localparam logic [PW-1:0] LAT_LAST = PW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   data_r;
  logic          dir_r;
  logic [5:0]    len_r;
  logic [5:0]    bit_cnt;
  logic [PW-1:0] ph_cnt;
  logic [1:0]    mode;
  logic          last_bit;
  logic          sh_q_unused;

  // Only the two end bits of the register are observed; the rest is feedback we never need.
  assign sh_q_unused = ^sh_Q[30:1];
  assign last_bit    = (bit_cnt == len_r - 6'd1);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers: captured transfer parameters plus bit/phase counters.
  // The phase counter doubles as the LATCH hold timer.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      data_r  <= '0;
      dir_r   <= 1'b0;
      len_r   <= '0;
      bit_cnt <= '0;
      ph_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          ph_cnt  <= '0;
          if (start) begin
            data_r <= pdata;
            dir_r  <= dir;
            len_r  <= (len == 6'd0 || len > 6'd32) ? 6'd32 : len;
          end
        end
        SHIFT: begin
          if (ph_cnt == PH_LAST) begin
            ph_cnt <= '0;
            if (!last_bit) bit_cnt <= bit_cnt + 6'd1;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (ph_cnt == LAT_LAST) ph_cnt <= '0;
          else                    ph_cnt <= ph_cnt + 1'b1;
        end
        default: begin
          bit_cnt <= '0;
          ph_cnt  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mode      = 2'b00;
    sh_SL     = 1'b0;
    sh_SR     = 1'b0;
    sh_PData  = '0;
    sout      = 1'b0;
    sclk      = 1'b0;
    latch     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        mode      = 2'b11;
        sh_PData  = data_r;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy  = 1'b1;
        sh_SL = fill;
        sh_SR = fill;
        sout  = dir_r ? sh_Q[0] : sh_Q[31];
        sclk  = (ph_cnt >= PH_HALF);
        // Advance the register only after sclk has been high for a full half period.
        if (ph_cnt == PH_LAST) begin
          mode = dir_r ? 2'b01 : 2'b10;
          if (last_bit) state_nxt = LATCH;
        end
      end
      LATCH: begin
        busy  = 1'b1;
        latch = 1'b1;
        if (ph_cnt == LAT_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sh_S1 = mode[1];
  assign sh_S0 = mode[0];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench: stimulus queues expected transfers and bits; monitors check them as the sequencers emit them.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear, start, dir, fill;
  logic [31:0] pdata, sh_q, pd;
  logic [5:0]  len;
  logic        s1, s0, sl, sr, sout, sclk, latch, busy, done;

  logic        start1, dir1, fill1;
  logic [31:0] pdata1, sh_q1, pd1;
  logic [5:0]  len1;
  logic        s1_1, s0_1, sl1, sr1, sout1, sclk1, latch1, busy1, done1;

  shift_seq_ctrl #(.DIV(2)) dut (
    .clk(clk), .clear(clear), .start(start), .pdata(pdata), .dir(dir), .len(len), .fill(fill),
    .sh_Q(sh_q), .sh_S1(s1), .sh_S0(s0), .sh_SL(sl), .sh_SR(sr), .sh_PData(pd),
    .sout(sout), .sclk(sclk), .latch(latch), .busy(busy), .done(done));

  shift_seq_ctrl #(.DIV(1)) dut1 (
    .clk(clk), .clear(clear), .start(start1), .pdata(pdata1), .dir(dir1), .len(len1), .fill(fill1),
    .sh_Q(sh_q1), .sh_S1(s1_1), .sh_S0(s0_1), .sh_SL(sl1), .sh_SR(sr1), .sh_PData(pd1),
    .sout(sout1), .sclk(sclk1), .latch(latch1), .busy(busy1), .done(done1));

  // External 32-bit universal shift registers
  always @(posedge clk or posedge clear) begin
    if (clear) sh_q <= '0;
    else case ({s1, s0})
      2'b01:   sh_q <= {sr, sh_q[31:1]};
      2'b10:   sh_q <= {sh_q[30:0], sl};
      2'b11:   sh_q <= pd;
      default: sh_q <= sh_q;
    endcase
  end

  always @(posedge clk or posedge clear) begin
    if (clear) sh_q1 <= '0;
    else case ({s1_1, s0_1})
      2'b01:   sh_q1 <= {sr1, sh_q1[31:1]};
      2'b10:   sh_q1 <= {sh_q1[30:0], sl1};
      2'b11:   sh_q1 <= pd1;
      default: sh_q1 <= sh_q1;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          done_ofs;
    int          nbits;
    int          latch_n;
    logic [31:0] word;
    int          gap;
  } xfer_t;

  xfer_t xq[$];
  bit    bq[$];
  xfer_t xq1[$];
  bit    bq1[$];

  int load_cnt = 0, done_cnt = 0, mon_sclk_n = 0, done1_cnt = 0;

  // Monitor for the DIV=2 instance
  initial begin
    xfer_t cur;
    bit    active = 0, prev_sclk = 0;
    int    load_cyc = 0, latch_n = 0, last_done = 0;
    forever begin
      @(negedge clk);
      if (clear) begin
        if (active) chk("abort_sclk_pulses", mon_sclk_n, cur.nbits);
        active = 0;
        prev_sclk = 0;
      end else begin
        if ({s1, s0} == 2'b11) begin
          load_cnt++;
          chk("load_expected", xq.size() != 0, 1);
          if (xq.size() != 0) begin
            cur = xq.pop_front();
            active = 1;
            load_cyc = cyc;
            mon_sclk_n = 0;
            latch_n = 0;
            chk("pdata_load", pd, cur.word);
            if (cur.gap > 0) chk("idle_gap", cyc - last_done, cur.gap);
          end
        end
        if (sclk && !prev_sclk) begin
          mon_sclk_n++;
          chk("bit_expected", bq.size() != 0, 1);
          if (bq.size() != 0) chk("sout_bit", sout, bq.pop_front());
        end
        if (latch) latch_n++;
        if (done) begin
          done_cnt++;
          last_done = cyc;
          chk("busy_in_done", busy, 0);
          chk("done_expected", active, 1);
          if (active) begin
            chk("done_cycle", cyc - load_cyc, cur.done_ofs);
            chk("sclk_pulses", mon_sclk_n, cur.nbits);
            chk("latch_cycles", latch_n, cur.latch_n);
          end
          active = 0;
        end
        prev_sclk = sclk;
      end
    end
  end

  // Monitor for the DIV=1 instance
  initial begin
    xfer_t cur;
    bit    active = 0, prev_sclk = 0;
    int    load_cyc = 0, sclk_n = 0, latch_n = 0;
    forever begin
      @(negedge clk);
      if (!clear) begin
        if ({s1_1, s0_1} == 2'b11) begin
          chk("d1_load_expected", xq1.size() != 0, 1);
          if (xq1.size() != 0) begin
            cur = xq1.pop_front();
            active = 1;
            load_cyc = cyc;
            sclk_n = 0;
            latch_n = 0;
          end
        end
        if (sclk1 && !prev_sclk) begin
          sclk_n++;
          chk("d1_bit_expected", bq1.size() != 0, 1);
          if (bq1.size() != 0) chk("d1_sout_bit", sout1, bq1.pop_front());
        end
        if (latch1) latch_n++;
        if (done1) begin
          done1_cnt++;
          chk("d1_done_expected", active, 1);
          if (active) begin
            chk("d1_done_cycle", cyc - load_cyc, cur.done_ofs);
            chk("d1_sclk_pulses", sclk_n, cur.nbits);
            chk("d1_latch_cycles", latch_n, cur.latch_n);
            chk("d1_fill_shifted_in", sh_q1, 32'h0000_0001);
          end
          active = 0;
        end
        prev_sclk = sclk1;
      end
    end
  end

  task automatic push_xfer(input logic [31:0] w, input logic d, input int n, input int ofs, input int gap);
    xfer_t x;
    x.done_ofs = ofs;
    x.nbits    = n;
    x.latch_n  = 2;
    x.word     = w;
    x.gap      = gap;
    xq.push_back(x);
    for (int k = 0; k < n; k++) bq.push_back(d ? w[k] : w[31-k]);
  endtask

  task automatic issue(input logic [31:0] w, input logic d, input logic [5:0] l, input logic f,
                       input int nbits, input int ofs);
    push_xfer(w, d, nbits, ofs, 0);
    @(negedge clk); #2;
    pdata = w; dir = d; len = l; fill = f; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 400 && done_cnt < n; i++) @(negedge clk);
    #1;
    chk("done_within_budget", done_cnt >= n, 1);
  endtask

  initial begin
    bit found;
    clear = 1'b1; start = 1'b0; pdata = '0; dir = 1'b0; len = '0; fill = 1'b0;
    start1 = 1'b0; pdata1 = '0; dir1 = 1'b0; len1 = '0; fill1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mode", {s1, s0}, 0);
    chk("rst_sclk_sout_latch_done", {sclk, sout, latch, done}, 0);
    chk("rst_pdata_out", pd, 0);
    @(negedge clk); #2 clear = 1'b0;

    // MSB first, 8 bits: 1,0,1,0,0,1,0,1
    issue(32'hA500_0000, 1'b0, 6'd8, 1'b0, 8, 35);
    wait_done(1);
    // LSB first, len 0 means 32 bits
    issue(32'h0000_0001, 1'b1, 6'd0, 1'b0, 32, 131);
    wait_done(2);

    // Second start and input changes mid-transfer are ignored
    issue(32'hC300_0000, 1'b0, 6'd6, 1'b1, 6, 27);
    repeat (6) @(negedge clk);
    #2 pdata = 32'hFFFF_FFFF; dir = 1'b1; len = 6'd2; start = 1'b1;
    @(negedge clk); #2 start = 1'b0;
    wait_done(3);

    // len above 32 clamps to 32
    issue(32'h1234_5678, 1'b1, 6'd40, 1'b0, 32, 131);
    wait_done(4);

    // Abort with clear during bit 5 of a 32-bit transfer
    push_xfer(32'h9F00_0000, 1'b0, 5, 0, 0);
    @(negedge clk); #2;
    pdata = 32'h9F00_0000; dir = 1'b0; len = 6'd0; start = 1'b1;
    @(negedge clk); #2 start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (mon_sclk_n == 5 && !sclk && busy) found = 1;
    end
    chk("reached_bit5", found, 1);
    clear = 1'b1;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_mode", {s1, s0}, 0);
    chk("clr_sclk_sout_latch", {sclk, sout, latch}, 0);
    @(negedge clk); #2 clear = 1'b0;
    chk("clr_bits_consumed", bq.size(), 0);

    // Fresh 4-bit transfer after abort
    issue(32'hA000_0000, 1'b0, 6'd4, 1'b0, 4, 19);
    wait_done(5);

    // start held high: two back-to-back transfers, one IDLE cycle between done and LOAD
    push_xfer(32'h6000_0000, 1'b0, 2, 11, 0);
    push_xfer(32'h6000_0000, 1'b0, 2, 11, 2);
    @(negedge clk); #2;
    pdata = 32'h6000_0000; dir = 1'b0; len = 6'd2; start = 1'b1;
    for (int i = 0; i < 100 && load_cnt < 8; i++) begin
      @(negedge clk); #1;
    end
    #1 start = 1'b0;
    wait_done(7);
    repeat (4) @(negedge clk);
    #1;
    chk("total_loads", load_cnt, 8);
    chk("scoreboard_empty", xq.size() + bq.size(), 0);

    // DIV=1, single bit, fill=1 shifted into Q[0]
    begin
      xfer_t x;
      x.done_ofs = 4; x.nbits = 1; x.latch_n = 1; x.word = 32'h8000_0000; x.gap = 0;
      xq1.push_back(x);
      bq1.push_back(1'b1);
    end
    @(negedge clk); #2;
    pdata1 = 32'h8000_0000; dir1 = 1'b0; len1 = 6'd1; fill1 = 1'b1; start1 = 1'b1;
    @(negedge clk); #2 start1 = 1'b0;
    for (int i = 0; i < 50 && done1_cnt < 1; i++) @(negedge clk);
    #1;
    chk("d1_done_within_budget", done1_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
